bus_master: RTL

Single-outstanding-transaction master for the native parallel bus. It accepts read/write requests on a valid/ready interface, sequences the r_wn/addr/wdata pins with setup, strobe and hold phases, and samples rdata. It returns one response per request. It sits directly upstream of one or more bus endpoints, whose outputs are OR-combined onto rdata.

---
 rtl/bus_pkg.sv | 18 +
 rtl/bus_master_if.sv | 33 +++
 rtl/bus_cycle_timer.sv | 26 ++
 rtl/bus_master.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared state enum and bus encodings for the parallel bus master
package bus_pkg;

    localparam int PHASE_CNT_W = 4;

    localparam logic BUS_READ  = 1'b1;
    localparam logic BUS_WRITE = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        WAIT,
        RESP
    } bus_master_state_t;

endpackage

// File: rtl/bus_master_if.sv
// rtl/bus_master_if.sv - request/response handshake and parallel bus pins of bus_master
interface bus_master_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic                  r_wn;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready, rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, r_wn, addr, wdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready, rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, r_wn, addr, wdata
    );

endinterface

// File: rtl/bus_cycle_timer.sv
// rtl/bus_cycle_timer.sv - loadable down-counter timing the STROBE and WAIT phases
module bus_cycle_timer
    import bus_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [PHASE_CNT_W-1:0] load_value,
    output logic [PHASE_CNT_W-1:0] value,
    output logic                   done
);

    // Saturates at zero; the FSM only looks at done while in a timed phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (value != '0) begin
            value <= value - 1'b1;
        end
    end

    assign done = (value == '0);

endmodule

// File: rtl/bus_master.sv
// rtl/bus_master.sv - single-outstanding parallel bus master; BUS_MASTER_RANGE_CHECK_EN enables the address range check
module bus_master
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int WR_PULSE   = 1,
    parameter int RD_WAIT    = 1,
    parameter int ADDR_LIMIT = 2**ADDR_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    bus_master_if.master bus
);

    localparam logic [PHASE_CNT_W-1:0] WR_LOAD = PHASE_CNT_W'(WR_PULSE - 1);
    localparam logic [PHASE_CNT_W-1:0] RD_LOAD = PHASE_CNT_W'(RD_WAIT - 1);
    localparam logic [ADDR_WIDTH:0]    LIMIT   = (ADDR_WIDTH+1)'(ADDR_LIMIT);

    bus_master_state_t state, state_next;

    logic                   is_write;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic                   accept;
    logic                   out_of_range;
    logic                   timer_load;
    logic [PHASE_CNT_W-1:0] timer_value;
    logic [PHASE_CNT_W-1:0] timer_count;
    logic                   timer_done;

    assign accept = bus.req_valid && (state == IDLE);

`ifdef BUS_MASTER_RANGE_CHECK_EN
    logic err_q;

    assign out_of_range = ({1'b0, bus.req_addr} >= LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= out_of_range;
        end
    end

    assign bus.rsp_err = err_q;
`else
    logic unused_limit;

    assign unused_limit = ^LIMIT;
    assign out_of_range = 1'b0;
    assign bus.rsp_err  = 1'b0;
`endif

    bus_cycle_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .load_value (timer_value),
        .value      (timer_count),
        .done       (timer_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        timer_load  = 1'b0;
        timer_value = WR_LOAD;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    state_next = out_of_range ? RESP : SETUP;
                end
            end
            SETUP: begin
                timer_load = 1'b1;
                if (is_write) begin
                    state_next  = STROBE;
                    timer_value = WR_LOAD;
                end else begin
                    state_next  = WAIT;
                    timer_value = RD_LOAD;
                end
            end
            STROBE: begin
                if (timer_done) begin
                    state_next = HOLD;
                end
            end
            HOLD: state_next = RESP;
            WAIT: begin
                if (timer_done) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Rejected requests leave the bus pins untouched so endpoints see nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_write <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            if (accept) begin
                rdata_q <= '0;
                if (!out_of_range) begin
                    is_write <= bus.req_write;
                    addr_q   <= bus.req_addr;
                    wdata_q  <= bus.req_wdata;
                end
            end
            if ((state == WAIT) && timer_done) begin
                rdata_q <= bus.rdata;
            end
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.r_wn      = (state == STROBE) ? BUS_WRITE : BUS_READ;
    assign bus.addr      = addr_q;
    assign bus.wdata     = wdata_q;

endmodule
